// File: rtl/vis_accumulator_if.sv
// vis_accumulator_if: bus bundle for the visibility accumulator.
//   count_i  : blocks per frame minus one, sampled at frame start
//   valid_i  : partial-sum strobe (no backpressure)
//   revis_i / imvis_i : signed real / imaginary partial sums
//   valid_o  : completed visibility strobe
//   first_o / last_o : address 0 / address TOTAL-1 of the frame
//   frame_o  : end-of-frame pulse, coincident with last_o
//   revis_o / imvis_o : signed full-width totals
// The master modport drives the inputs; the slave modport is the accumulator.
`timescale 1ns/1ps
interface vis_accumulator_if #(
  parameter int unsigned SBITS = 7,
  parameter int unsigned WIDTH = 36,
  parameter int unsigned KBITS = 16
);
  logic [KBITS-1:0] count_i;
  logic             valid_i;
  logic [SBITS-1:0] revis_i;
  logic [SBITS-1:0] imvis_i;
  logic             valid_o;
  logic             first_o;
  logic             last_o;
  logic             frame_o;
  logic [WIDTH-1:0] revis_o;
  logic [WIDTH-1:0] imvis_o;

  modport master (
    output count_i, valid_i, revis_i, imvis_i,
    input  valid_o, first_o, last_o, frame_o, revis_o, imvis_o
  );

  modport slave (
    input  count_i, valid_i, revis_i, imvis_i,
    output valid_o, first_o, last_o, frame_o, revis_o, imvis_o
  );
endinterface

// File: rtl/vis_accumulator.sv
// vis_accumulator: final-stage visibility accumulator behind the correlator
// daisy-chain. Sums each of TOTAL = CORES*TRATE signed visibilities over
// kmax+1 blocks in read-modify-write RAM and streams the totals out.
//   vis_clock : sole clock
//   reset_n   : synchronous, active-low reset (RAM contents are kept)
//   bus       : slave side of vis_accumulator_if (inputs, totals, markers)
// Two-stage pipeline: S0 registers the sample and reads RAM, S1 adds and
// either writes back or drives the outputs. Latency from valid_i to valid_o
// is two cycles.
`timescale 1ns/1ps
module vis_accumulator #(
  parameter int unsigned CORES = 18,
  parameter int unsigned TRATE = 30,
  parameter int unsigned ABITS = 10,
  parameter int unsigned SBITS = 7,
  parameter int unsigned WIDTH = 36,
  parameter int unsigned KBITS = 16
) (
  input  logic            vis_clock,
  input  logic            reset_n,
  vis_accumulator_if.slave bus
);
  localparam int unsigned TOTAL = CORES * TRATE;
  localparam logic [ABITS-1:0] ALAST = ABITS'(TOTAL - 1);

  logic [ABITS-1:0] addr;
  logic [KBITS-1:0] blk;
  logic [KBITS-1:0] kmax;
  logic [KBITS-1:0] kmax_cur;
  logic             frame_start;
  logic             blk_first;
  logic             blk_last;

  logic             s0_valid;
  logic [ABITS-1:0] s0_addr;
  logic             s0_clear;
  logic             s0_emit;
  logic [SBITS-1:0] s0_re;
  logic [SBITS-1:0] s0_im;
  logic [WIDTH-1:0] rd_re;
  logic [WIDTH-1:0] rd_im;
  logic [WIDTH-1:0] sum_re;
  logic [WIDTH-1:0] sum_im;

  logic [WIDTH-1:0] mem_re [TOTAL];
  logic [WIDTH-1:0] mem_im [TOTAL];

  // At the first sample of a frame count_i is used directly, so the block
  // limit applies to that very sample (kmax==0 emits immediately).
  always_comb begin
    frame_start = (addr == '0) && (blk == '0);
    kmax_cur    = frame_start ? bus.count_i : kmax;
    blk_first   = (blk == '0);
    blk_last    = (blk == kmax_cur);
  end

  always_ff @(posedge vis_clock) begin
    if (!reset_n) begin
      addr <= '0;
      blk  <= '0;
      kmax <= '0;
    end else if (bus.valid_i) begin
      if (frame_start) kmax <= bus.count_i;
      if (addr == ALAST) begin
        addr <= '0;
        blk  <= blk_last ? '0 : blk + KBITS'(1);
      end else begin
        addr <= addr + ABITS'(1);
      end
    end
  end

  // S0 control
  always_ff @(posedge vis_clock) begin
    if (!reset_n) s0_valid <= 1'b0;
    else          s0_valid <= bus.valid_i;
  end

  // S0 data and RAM read; no reset needed, qualified by s0_valid
  always_ff @(posedge vis_clock) begin
    s0_addr  <= addr;
    s0_clear <= blk_first;
    s0_emit  <= blk_last;
    s0_re    <= bus.revis_i;
    s0_im    <= bus.imvis_i;
    rd_re    <= mem_re[addr];
    rd_im    <= mem_im[addr];
  end

  // Block 0 ignores the stale RAM word, which clears the accumulator
  always_comb begin
    sum_re = (s0_clear ? '0 : rd_re) + WIDTH'(signed'(s0_re));
    sum_im = (s0_clear ? '0 : rd_im) + WIDTH'(signed'(s0_im));
  end

  always_ff @(posedge vis_clock) begin
    if (s0_valid && !s0_emit) begin
      mem_re[s0_addr] <= sum_re;
      mem_im[s0_addr] <= sum_im;
    end
  end

  always_ff @(posedge vis_clock) begin
    if (!reset_n) begin
      bus.valid_o <= 1'b0;
      bus.first_o <= 1'b0;
      bus.last_o  <= 1'b0;
      bus.frame_o <= 1'b0;
      bus.revis_o <= '0;
      bus.imvis_o <= '0;
    end else begin
      bus.valid_o <= s0_valid && s0_emit;
      bus.first_o <= s0_valid && s0_emit && (s0_addr == '0);
      bus.last_o  <= s0_valid && s0_emit && (s0_addr == ALAST);
      bus.frame_o <= s0_valid && s0_emit && (s0_addr == ALAST);
      if (s0_valid && s0_emit) begin
        bus.revis_o <= sum_re;
        bus.imvis_o <= sum_im;
      end
    end
  end
endmodule

// File: tb/tb_vis_accumulator.sv
// tb_vis_accumulator: randomized self-checking bench for vis_accumulator,
// CORES=2, TRATE=3 (TOTAL=6), plus an 8-bit-wide instance for wraparound.
`timescale 1ns/1ps
module tb_vis_accumulator;
  localparam int TOTAL = 6;

  logic vis_clock = 1'b0;
  logic reset_n   = 1'b0;
  always #5 vis_clock = ~vis_clock;

  vis_accumulator_if #(.SBITS(7), .WIDTH(36), .KBITS(16)) bus ();
  vis_accumulator_if #(.SBITS(8), .WIDTH(8),  .KBITS(16)) bus8 ();

  vis_accumulator #(.CORES(2), .TRATE(3), .ABITS(3), .SBITS(7), .WIDTH(36), .KBITS(16)) dut (
    .vis_clock (vis_clock),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  vis_accumulator #(.CORES(2), .TRATE(3), .ABITS(3), .SBITS(8), .WIDTH(8), .KBITS(16)) dut8 (
    .vis_clock (vis_clock),
    .reset_n   (reset_n),
    .bus       (bus8)
  );

  int cyc = 0;
  always @(posedge vis_clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [35:0] re;
    logic [35:0] im;
    logic        first;
    logic        last;
    logic        frame;
    int          stamp;
  } beat_t;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
    logic       first;
    logic       last;
    logic       frame;
  } beat8_t;

  beat_t  obs_q[$];
  beat_t  exp_q[$];
  beat8_t obs8_q[$];

  always @(negedge vis_clock) begin
    if (bus.valid_o === 1'b1)
      obs_q.push_back({bus.revis_o, bus.imvis_o, bus.first_o, bus.last_o, bus.frame_o, cyc});
    if (bus8.valid_o === 1'b1)
      obs8_q.push_back({bus8.revis_o, bus8.imvis_o, bus8.first_o, bus8.last_o, bus8.frame_o});
  end

  // Reference: position within the frame decides block and address; the
  // running per-address sums are emitted on the frame's final block.
  int     m_pos  = 0;
  int     m_kmax = 0;
  longint m_re [TOTAL];
  longint m_im [TOTAL];

  task automatic send(input int re, input int im, input int cnt, input int gap_pct);
    int a;
    int b;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      @(negedge vis_clock);
      bus.valid_i = 1'b0;
    end
    @(negedge vis_clock);
    bus.valid_i = 1'b1;
    bus.revis_i = 7'(re);
    bus.imvis_i = 7'(im);
    bus.count_i = 16'(cnt);
    if (m_pos == 0) m_kmax = cnt;
    a = m_pos % TOTAL;
    b = m_pos / TOTAL;
    if (b == 0) begin
      m_re[a] = re;
      m_im[a] = im;
    end else begin
      m_re[a] += re;
      m_im[a] += im;
    end
    if (b == m_kmax)
      exp_q.push_back({36'(m_re[a]), 36'(m_im[a]), a == 0, a == TOTAL - 1, a == TOTAL - 1, cyc + 2});
    m_pos = (m_pos + 1) % ((m_kmax + 1) * TOTAL);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge vis_clock);
      bus.valid_i = 1'b0;
    end
  endtask

  function automatic int rnd7();
    return int'($urandom_range(127)) - 64;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    bus.valid_i = 1'b0; bus.count_i = '0; bus.revis_i = '0; bus.imvis_i = '0;
    bus8.valid_i = 1'b0; bus8.count_i = '0; bus8.revis_i = '0; bus8.imvis_i = '0;
    repeat (3) @(negedge vis_clock);
    reset_n = 1'b1;
    m_pos = 0;
    n_checks++;
    if ({bus.valid_o, bus.first_o, bus.last_o, bus.frame_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, want 0000", {bus.valid_o, bus.first_o, bus.last_o, bus.frame_o});
    end
    n_checks++;
    if (bus.revis_o !== 36'd0 || bus.imvis_o !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_data: got re=%h im=%h, want 0", bus.revis_o, bus.imvis_o);
    end
    n_checks++;
    if ({bus8.valid_o, bus8.revis_o, bus8.imvis_o} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_dut8: got v=%b re=%h im=%h, want 0", bus8.valid_o, bus8.revis_o, bus8.imvis_o);
    end
  endtask

  task automatic test_passthrough();
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 6; k++) send(k, -k, 0, 0);
    idle(4);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL passthru_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL passthru_beat%0d: got re=%0d im=%0d flf=%b%b%b t=%0d, want re=%0d im=%0d flf=%b%b%b t=%0d", i,
                 $signed(obs_q[i].re), $signed(obs_q[i].im), obs_q[i].first, obs_q[i].last, obs_q[i].frame, obs_q[i].stamp,
                 $signed(exp_q[i].re), $signed(exp_q[i].im), exp_q[i].first, exp_q[i].last, exp_q[i].frame, exp_q[i].stamp);
      end
    end
  endtask

  task automatic test_constant();
    int t0;
    obs_q.delete(); exp_q.delete();
    t0 = cyc;
    for (int i = 0; i < 24; i++) send(63, -64, 3, 0);
    idle(4);
    n_checks++;
    if (obs_q.size() !== 6) begin
      n_fail++;
      $display("FAIL const_count: got %0d beats, want 6", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      n_checks++;
      if (obs_q[i].re !== 36'd252 || obs_q[i].im !== -36'sd256 || obs_q[i].stamp < t0 + 18 + 2) begin
        n_fail++;
        $display("FAIL const_beat%0d: got re=%0d im=%0d t=%0d, want re=252 im=-256 t>=%0d", i,
                 $signed(obs_q[i].re), $signed(obs_q[i].im), obs_q[i].stamp, t0 + 20);
      end
    end
    m_pos = 0;
  endtask

  task automatic test_random_gaps();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 36; i++) send(rnd7(), rnd7(), 2, 50);
    idle(4);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gaps_beat%0d: got re=%0d im=%0d flf=%b%b%b t=%0d, want re=%0d im=%0d flf=%b%b%b t=%0d", i,
                 $signed(obs_q[i].re), $signed(obs_q[i].im), obs_q[i].first, obs_q[i].last, obs_q[i].frame, obs_q[i].stamp,
                 $signed(exp_q[i].re), $signed(exp_q[i].im), exp_q[i].first, exp_q[i].last, exp_q[i].frame, exp_q[i].stamp);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 12; i++) send(rnd7(), rnd7(), (i == 0) ? 1 : 4, 0);
    for (int i = 0; i < 30; i++) send(rnd7(), rnd7(), 4, 0);
    idle(4);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got re=%0d im=%0d flf=%b%b%b t=%0d, want re=%0d im=%0d flf=%b%b%b t=%0d", i,
                 $signed(obs_q[i].re), $signed(obs_q[i].im), obs_q[i].first, obs_q[i].last, obs_q[i].frame, obs_q[i].stamp,
                 $signed(exp_q[i].re), $signed(exp_q[i].im), exp_q[i].first, exp_q[i].last, exp_q[i].frame, exp_q[i].stamp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    obs_q.delete(); exp_q.delete();
    // blocks 0 and 1 up to addr 2; reset lands where block 1 addr 3 would go
    for (int i = 0; i < 9; i++) send(60, -60, 2, 0);
    @(negedge vis_clock);
    bus.valid_i = 1'b0;
    reset_n = 1'b0;
    @(negedge vis_clock);
    reset_n = 1'b1;
    n_checks++;
    if ({bus.valid_o, bus.first_o, bus.last_o, bus.frame_o} !== 4'b0 || bus.revis_o !== 36'd0 || bus.imvis_o !== 36'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%b f=%b l=%b fr=%b re=%h im=%h, want all 0",
               bus.valid_o, bus.first_o, bus.last_o, bus.frame_o, bus.revis_o, bus.imvis_o);
    end
    m_pos = 0;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 18; i++) send(rnd7(), rnd7(), 2, 0);
    idle(4);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midreset_beat%0d: got re=%0d im=%0d flf=%b%b%b t=%0d, want re=%0d im=%0d flf=%b%b%b t=%0d", i,
                 $signed(obs_q[i].re), $signed(obs_q[i].im), obs_q[i].first, obs_q[i].last, obs_q[i].frame, obs_q[i].stamp,
                 $signed(exp_q[i].re), $signed(exp_q[i].im), exp_q[i].first, exp_q[i].last, exp_q[i].frame, exp_q[i].stamp);
      end
    end
  endtask

  task automatic test_wrap();
    obs8_q.delete();
    for (int i = 0; i < 30; i++) begin
      @(negedge vis_clock);
      bus8.valid_i = 1'b1;
      bus8.revis_i = 8'd127;
      bus8.imvis_i = 8'h80;
      bus8.count_i = 16'd4;
    end
    @(negedge vis_clock);
    bus8.valid_i = 1'b0;
    repeat (4) @(negedge vis_clock);
    n_checks++;
    if (obs8_q.size() !== 6) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d beats, want 6", obs8_q.size());
    end
    // 5*127 = 635 -> 123 mod 256; 5*(-128) = -640 -> 128 mod 256
    for (int i = 0; i < obs8_q.size() && i < 6; i++) begin
      n_checks++;
      if (obs8_q[i].re !== 8'd123 || obs8_q[i].im !== 8'd128 || obs8_q[i].first !== (i == 0) ||
          obs8_q[i].last !== (i == 5) || obs8_q[i].frame !== (i == 5)) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: got re=%0d im=%0d flf=%b%b%b, want re=123 im=128 flf=%b%b%b", i,
                 obs8_q[i].re, obs8_q[i].im, obs8_q[i].first, obs8_q[i].last, obs8_q[i].frame,
                 i == 0, i == 5, i == 5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_constant();
    test_random_gaps();
    test_back_to_back();
    test_reset_midframe();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
